// File: rtl/nios_soc_pio_pkg.sv
// Shared register map and edge-type definitions for the nios_soc PIO blocks.
package nios_soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } pio_edge_e;

  // Unknown encodings fall back to rising-edge capture.
  function automatic logic [31:0] pio_edge_event(input logic [31:0] cur,
                                                 input logic [31:0] prev,
                                                 input pio_edge_e   kind);
    logic [31:0] ev;
    case (kind)
      EDGE_FALLING: ev = ~cur & prev;
      EDGE_ANY:     ev = cur ^ prev;
      default:      ev = cur & ~prev;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input pin: two-flop synchroniser followed by a stable-count debouncer.
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_deb
);

  // A zero count would never match, so it behaves as a single-cycle filter.
  localparam int D     = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CNT_W = $clog2(D + 1);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(D - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_TC) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/nios_soc_keys_pio.sv
// Avalon-MM input PIO for keys/switches: debounced data, edge capture with
// write-1-to-clear, interrupt mask and a registered level IRQ.
module nios_soc_keys_pio
  import nios_soc_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam pio_edge_e EDGE_KIND = pio_edge_e'(2'(EDGE_TYPE));

  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_ec;
  logic [WIDTH-1:0] r_mask;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .i_pin  (in_port[gi]),
      .o_deb  (w_deb[gi])
    );
  end

  assign w_wr           = chipselect && !write_n;
  assign w_clr          = (w_wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign w_ev           = WIDTH'(pio_edge_event(32'(w_deb), 32'(r_prev), EDGE_KIND));
  assign w_unused_wdata = ^writedata;

  always_comb begin
    w_rdata = '0;
    case (address)
      PIO_ADDR_DATA:    w_rdata[WIDTH-1:0] = w_deb;
      PIO_ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_mask;
      PIO_ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_ec;
      default:          w_rdata = '0;
    endcase
  end

  // A new edge is OR-ed in after the clear, so a colliding set survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev   <= '0;
      r_ec     <= '0;
      r_mask   <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      r_prev   <= w_deb;
      r_ec     <= (r_ec & ~w_clr) | w_ev;
      irq      <= |(r_ec & r_mask);
      readdata <= w_rdata;
      if (w_wr && address == PIO_ADDR_IRQMASK) begin
        r_mask <= writedata[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_nios_soc_keys_pio.sv
// Directed bench for nios_soc_keys_pio with DEBOUNCE_CYCLES=4; a rising-edge
// and an any-edge instance share the same bus and pins.
module tb_nios_soc_keys_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_port = 4'h0;
  logic [31:0] rd_r, rd_a;
  logic        irq_r, irq_a;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  nios_soc_keys_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r)
  );

  nios_soc_keys_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_port = 4'hF;
    ticks(3);
    n_total++; if (rd_r !== 32'd0) $display("FAIL reset_rd_r got %h exp %h", rd_r, 32'd0); else n_pass++;
    n_total++; if (irq_r !== 1'b0) $display("FAIL reset_irq_r got %b exp 0", irq_r); else n_pass++;
    n_total++; if (rd_a !== 32'd0) $display("FAIL reset_rd_a got %h exp %h", rd_a, 32'd0); else n_pass++;
    n_total++; if (irq_a !== 1'b0) $display("FAIL reset_irq_a got %b exp 0", irq_a); else n_pass++;
    reset_n = 1'b1;
    address = 2'd0;
    ticks(6);
    n_total++; if (rd_r !== 32'd0) $display("FAIL rel_data_e5 got %h exp %h", rd_r, 32'd0); else n_pass++;
    tick();
    n_total++; if (rd_r !== 32'hF) $display("FAIL rel_data_e6 got %h exp %h", rd_r, 32'hF); else n_pass++;
    bus_rd(2'd3);
    n_total++; if (rd_r !== 32'hF) $display("FAIL rel_ec got %h exp %h", rd_r, 32'hF); else n_pass++;
    n_total++; if (irq_r !== 1'b0) $display("FAIL rel_irq_masked got %b exp 0", irq_r); else n_pass++;
    bus_wr(2'd3, 32'hF);
    bus_rd(2'd3);
    n_total++; if (rd_r !== 32'd0) $display("FAIL rel_ec_clr got %h exp %h", rd_r, 32'd0); else n_pass++;
  endtask

  task automatic test_debounce();
    in_port = 4'h0;
    ticks(10);
    bus_wr(2'd3, 32'hF);
    in_port = 4'h1;
    ticks(3);
    in_port = 4'h0;
    ticks(10);
    bus_rd(2'd0);
    n_total++; if (rd_r !== 32'd0) $display("FAIL glitch_data got %h exp %h", rd_r, 32'd0); else n_pass++;
    bus_rd(2'd3);
    n_total++; if (rd_r !== 32'd0) $display("FAIL glitch_ec got %h exp %h", rd_r, 32'd0); else n_pass++;
    address = 2'd0;
    in_port = 4'h1;
    ticks(6);
    n_total++; if (rd_r !== 32'd0) $display("FAIL stable_data_e5 got %h exp %h", rd_r, 32'd0); else n_pass++;
    tick();
    n_total++; if (rd_r !== 32'd1) $display("FAIL stable_data_e6 got %h exp %h", rd_r, 32'd1); else n_pass++;
    in_port = 4'h0;
    ticks(10);
    bus_wr(2'd3, 32'hF);
  endtask

  task automatic test_edge_irq();
    bus_wr(2'd2, 32'h2);
    in_port = 4'b0010;
    address = 2'd3;
    ticks(7);
    n_total++; if (rd_r !== 32'd0) $display("FAIL edge_ec_e6 got %h exp %h", rd_r, 32'd0); else n_pass++;
    n_total++; if (irq_r !== 1'b0) $display("FAIL edge_irq_e6 got %b exp 0", irq_r); else n_pass++;
    tick();
    n_total++; if (rd_r !== 32'h2) $display("FAIL edge_ec_e7 got %h exp %h", rd_r, 32'h2); else n_pass++;
    n_total++; if (irq_r !== 1'b1) $display("FAIL edge_irq_e7 got %b exp 1", irq_r); else n_pass++;
    bus_wr(2'd3, 32'h2);
    n_total++; if (irq_r !== 1'b1) $display("FAIL clr_irq_same got %b exp 1", irq_r); else n_pass++;
    tick();
    n_total++; if (irq_r !== 1'b0) $display("FAIL clr_irq_next got %b exp 0", irq_r); else n_pass++;
    bus_rd(2'd3);
    n_total++; if (rd_r !== 32'd0) $display("FAIL clr_ec got %h exp %h", rd_r, 32'd0); else n_pass++;
  endtask

  task automatic test_mask();
    in_port = 4'b0110;
    ticks(10);
    bus_rd(2'd3);
    n_total++; if (rd_r !== 32'h4) $display("FAIL mask_ec got %h exp %h", rd_r, 32'h4); else n_pass++;
    n_total++; if (irq_r !== 1'b0) $display("FAIL mask_irq_gated got %b exp 0", irq_r); else n_pass++;
    bus_wr(2'd2, 32'h4);
    n_total++; if (irq_r !== 1'b0) $display("FAIL mask_irq_same got %b exp 0", irq_r); else n_pass++;
    tick();
    n_total++; if (irq_r !== 1'b1) $display("FAIL mask_irq_next got %b exp 1", irq_r); else n_pass++;
    bus_wr(2'd3, 32'hF);
    tick();
    n_total++; if (irq_r !== 1'b0) $display("FAIL mask_irq_clr got %b exp 0", irq_r); else n_pass++;
  endtask

  task automatic test_collision();
    in_port = 4'b0111;
    ticks(6);
    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3);
    n_total++; if (rd_r !== 32'h1) $display("FAIL collide_ec got %h exp %h", rd_r, 32'h1); else n_pass++;
    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3);
    n_total++; if (rd_r !== 32'h0) $display("FAIL w1c_ec got %h exp %h", rd_r, 32'h0); else n_pass++;
    in_port = 4'b1111;
    ticks(10);
    bus_wr(2'd3, 32'hF);
    in_port = 4'b0111;
    ticks(10);
    bus_rd(2'd3);
    n_total++; if (rd_a !== 32'h8) $display("FAIL any_fall_ec got %h exp %h", rd_a, 32'h8); else n_pass++;
    n_total++; if (rd_r !== 32'h0) $display("FAIL rise_fall_ec got %h exp %h", rd_r, 32'h0); else n_pass++;
  endtask

  task automatic test_regmap();
    bus_wr(2'd0, 32'hFFFF_FFFF);
    bus_wr(2'd1, 32'hFFFF_FFFF);
    bus_rd(2'd0);
    n_total++; if (rd_r !== 32'h7) $display("FAIL map_data got %h exp %h", rd_r, 32'h7); else n_pass++;
    bus_rd(2'd1);
    n_total++; if (rd_r !== 32'h0) $display("FAIL map_rsvd got %h exp %h", rd_r, 32'h0); else n_pass++;
    bus_rd(2'd2);
    n_total++; if (rd_r !== 32'h4) $display("FAIL map_mask_kept got %h exp %h", rd_r, 32'h4); else n_pass++;
    bus_wr(2'd2, 32'hFFFF_FFFF);
    bus_rd(2'd2);
    n_total++; if (rd_r !== 32'hF) $display("FAIL map_mask_all got %h exp %h", rd_r, 32'hF); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0d checks", n_total);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_debounce();
    test_edge_irq();
    test_mask();
    test_collision();
    test_regmap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
